// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: FSM states,
// parity types, legal oversampling ratios and small arithmetic helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_X8  = 6'd8;
    localparam logic [5:0] PRESCALE_X16 = 6'd16;
    localparam logic [5:0] PRESCALE_X32 = 6'd32;

    // Saturating 8-bit increment used by the error event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter with wrap at prescale-1 and a data bit counter
// that advances once per completed bit.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      bit_clr,
    input  logic                      bit_en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      bit_end
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_r;
    logic                      bit_end_s;

    assign bit_end_s = en && (edge_cnt_r == (prescale - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1}));

    // Edge index within the current bit; parked at zero while disabled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_r <= '0;
        end else if (clr || !en || bit_end_s) begin
            edge_cnt_r <= '0;
        end else begin
            edge_cnt_r <= edge_cnt_r + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Data bit index, restarted before the first payload bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_r <= '0;
        end else if (bit_clr) begin
            bit_cnt_r <= '0;
        end else if (bit_en && bit_end_s) begin
            bit_cnt_r <= bit_cnt_r + {{(BIT_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign edge_cnt = edge_cnt_r;
    assign bit_cnt  = bit_cnt_r;
    assign bit_end  = bit_end_s;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, deserialisation, parity and
// stop checks. Define UART_RX_ERR_CNT_EN to add saturating error counters.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      sample_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]                par_err_cnt,
    output logic [7:0]                stop_err_cnt
`endif
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    rx_state_e                 state_r, next_state_s;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic                      par_en_r;
    logic                      par_typ_r;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_s;
    logic                      bit_end_s;
    logic                      start_det_s;
    logic                      cfg_load_s;
    logic                      cnt_en_s;
    logic                      par_bad_s;
    logic                      last_data_s;

    // Expected parity bit for the received payload.
    function automatic logic par_bit_f(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    assign cnt_en_s    = (state_r != ST_IDLE);
    assign par_bad_s   = (sampled_bit != par_bit_f(shift_r, par_typ_r));
    assign last_data_s = (bit_cnt_s == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
    assign cfg_load_s  = start_det_s || ((state_r == ST_STOP) && bit_end_s && !RX_IN);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .en       (cnt_en_s),
        .clr      (start_det_s),
        .bit_clr  (state_r == ST_START),
        .bit_en   (state_r == ST_DATA),
        .prescale (prescale_r),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt_s),
        .bit_end  (bit_end_s)
    );

    // Next-state decode; only bit_end cycles move between frame phases.
    always_comb begin
        next_state_s = state_r;
        start_det_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!RX_IN) begin
                    next_state_s = ST_START;
                    start_det_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    next_state_s = sampled_bit ? ST_IDLE : ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && last_data_s) begin
                    next_state_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    next_state_s = RX_IN ? ST_IDLE : ST_START;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame configuration is frozen at each start so mid-frame changes cannot corrupt it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_r <= PRESCALE_X8;
            par_en_r   <= 1'b0;
            par_typ_r  <= PAR_EVEN;
        end else if (cfg_load_s) begin
            prescale_r <= prescale;
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
        end
    end

    // Payload shift register; LSB arrives first so bits enter at the top.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_r <= '0;
        end else if ((state_r == ST_DATA) && bit_end_s) begin
            shift_r <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
        end
    end

    // Registered outputs: sampler enable, byte delivery and error flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sample_en  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            sample_en  <= (next_state_s != ST_IDLE);
            data_valid <= 1'b0;
            if (start_det_s) begin
                par_err  <= 1'b0;
                stop_err <= 1'b0;
            end
            if ((state_r == ST_PARITY) && bit_end_s) begin
                par_err <= par_bad_s;
            end
            if ((state_r == ST_STOP) && bit_end_s) begin
                stop_err <= ~sampled_bit;
                if (sampled_bit && !par_err) begin
                    P_DATA     <= shift_r;
                    data_valid <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Error event counters, saturating and cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt  <= 8'd0;
            stop_err_cnt <= 8'd0;
        end else begin
            if ((state_r == ST_PARITY) && bit_end_s && par_bad_s) begin
                par_err_cnt <= sat_inc8(par_err_cnt);
            end
            if ((state_r == ST_STOP) && bit_end_s && !sampled_bit) begin
                stop_err_cnt <= sat_inc8(stop_err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a closed-loop 3-sample
// majority-vote sampler driven by the DUT's edge_cnt/sample_en.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit;
    logic [5:0] edge_cnt;
    logic       sample_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] par_err_cnt;
    logic [7:0] stop_err_cnt;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         dv_count = 0;
    int         last_dv_cyc = 0;
    logic [7:0] rx_q[$];
    logic [5:0] frame_p = 6'd8;
    logic [5:0] half_s;
    logic       s0_r, s1_r, s2_r;

    uart_rx_frame_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .sample_en   (sample_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stop_err    (stop_err)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .par_err_cnt (par_err_cnt),
        .stop_err_cnt(stop_err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference sampler: three samples around mid-bit, majority vote.
    assign half_s = frame_p >> 1;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_r <= 1'b1;
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else if (sample_en) begin
            if (edge_cnt == half_s - 6'd1) s0_r <= RX_IN;
            if (edge_cnt == half_s)        s1_r <= RX_IN;
            if (edge_cnt == half_s + 6'd1) s2_r <= RX_IN;
        end
    end
    assign sampled_bit = (s0_r & s1_r) | (s0_r & s2_r) | (s1_r & s2_r);

    // Collect every delivered byte away from the active edge.
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_count    = dv_count + 1;
            last_dv_cyc = cyc;
            rx_q.push_back(P_DATA);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        wait_cycles(p);
    endtask

    // One frame on the line; poke changes DUT config inputs mid-frame.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit, input logic poke);
        logic [5:0] save_p;
        logic       save_t;
        frame_p  = 6'(p);
        prescale = 6'(p);
        PAR_EN   = pen;
        save_p   = prescale;
        save_t   = PAR_TYP;
        drive_bit(1'b0, p);
        if (poke) begin
            prescale = 6'd16;
            PAR_TYP  = ~PAR_TYP;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
        if (poke) begin
            prescale = save_p;
            PAR_TYP  = save_t;
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        int dv0;
        int t0;

        wait_cycles(3);
        check("rst_edge_cnt",   32'(edge_cnt),   32'd0);
        check("rst_sample_en",  32'(sample_en),  32'd0);
        check("rst_p_data",     32'(P_DATA),     32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err",    32'(par_err),    32'd0);
        check("rst_stop_err",   32'(stop_err),   32'd0);
        RST = 1'b1;
        wait_cycles(4);

        // 1: x8, no parity, 0xA5
        dv0 = dv_count;
        t0  = cyc + 1;
        PAR_TYP = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cycles(6);
        check("t1_dv_count", 32'(dv_count - dv0), 32'd1);
        check("t1_p_data",   32'(P_DATA),         32'hA5);
        check("t1_par_err",  32'(par_err),        32'd0);
        check("t1_stop_err", 32'(stop_err),       32'd0);
        check("t1_latency",  32'(last_dv_cyc - t0), 32'd80);
        check("t1_idle_sen", 32'(sample_en),      32'd0);

        // 2: x8, even parity, 0x37 with wrong parity 0; config poked mid-frame
        dv0 = dv_count;
        PAR_TYP = 1'b0;
        send_frame(8'h37, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_cycles(6);
        check("t2_par_err",  32'(par_err),        32'd1);
        check("t2_stop_err", 32'(stop_err),       32'd0);
        check("t2_dv_count", 32'(dv_count - dv0), 32'd0);
        check("t2_p_data",   32'(P_DATA),         32'hA5);

        // 3: x16, odd parity, 0x37 correct parity 0, stop bit 0
        dv0 = dv_count;
        PAR_TYP = 1'b1;
        send_frame(8'h37, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(6);
        check("t3_stop_err", 32'(stop_err),       32'd1);
        check("t3_par_err",  32'(par_err),        32'd0);
        check("t3_dv_count", 32'(dv_count - dv0), 32'd0);
        check("t3_p_data",   32'(P_DATA),         32'hA5);

        // 4: x16, 3-cycle glitch aborts in START
        dv0 = dv_count;
        frame_p  = 6'd16;
        prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        wait_cycles(3);
        RX_IN = 1'b1;
        check("t4_sen_active", 32'(sample_en), 32'd1);
        wait_cycles(24);
        check("t4_sen_idle",   32'(sample_en),        32'd0);
        check("t4_edge_cnt",   32'(edge_cnt),         32'd0);
        check("t4_dv_count",   32'(dv_count - dv0),   32'd0);

        // 5: x32, back-to-back 0x00 then 0xFF
        dv0 = dv_count;
        PAR_TYP = 1'b0;
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cycles(8);
        check("t5_dv_count", 32'(dv_count - dv0), 32'd2);
        if (rx_q.size() >= 2) begin
            check("t5_first",  32'(rx_q[rx_q.size()-2]), 32'h00);
            check("t5_second", 32'(rx_q[rx_q.size()-1]), 32'hFF);
        end else begin
            check("t5_queue_size", 32'(rx_q.size()), 32'd2);
        end

        // 6: async reset mid-DATA, then 0x5A
        frame_p  = 6'd8;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        wait_cycles(8);
        RX_IN = 1'b1;
        wait_cycles(8 * 3 + 3);
        check("t6_pre_sen", 32'(sample_en), 32'd1);
        RST = 1'b0;
        #1;
        check("t6_edge_cnt",   32'(edge_cnt),   32'd0);
        check("t6_sample_en",  32'(sample_en),  32'd0);
        check("t6_p_data",     32'(P_DATA),     32'd0);
        check("t6_data_valid", 32'(data_valid), 32'd0);
        check("t6_par_err",    32'(par_err),    32'd0);
        check("t6_stop_err",   32'(stop_err),   32'd0);
        RX_IN = 1'b1;
        wait_cycles(3);
        RST = 1'b1;
        wait_cycles(3);
        dv0 = dv_count;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cycles(6);
        check("t6_dv_count", 32'(dv_count - dv0), 32'd1);
        check("t6_p_data2",  32'(P_DATA),         32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
